// File: rtl/width_conv_fifo.sv
// Width-converting circular FIFO: PAR_WRITE words in per write beat, PAR_READ words out per read beat.
// Optional feature: define WCFIFO_ERR_EN to add a sticky err output for handshake protocol violations.
module width_conv_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int PAR_WRITE  = 2,
    parameter int PAR_READ   = 4,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int AF_THRESH  = 12,
    parameter int AE_THRESH  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [PAR_WRITE*DATA_WIDTH-1:0] wr_data,
    output logic                           rd_valid,
    input  logic                           rd_ready,
    output logic [PAR_READ*DATA_WIDTH-1:0]  rd_data,
    output logic [ADDR_WIDTH:0]            count,
    output logic                           full,
    output logic                           empty,
    output logic                           almost_full,
    output logic                           almost_empty
`ifdef WCFIFO_ERR_EN
    ,
    output logic                           err
`endif
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   WR_CNT    = (ADDR_WIDTH+1)'(PAR_WRITE);
    localparam logic [ADDR_WIDTH:0]   RD_CNT    = (ADDR_WIDTH+1)'(PAR_READ);
    localparam logic [ADDR_WIDTH:0]   AF_CNT    = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0]   AE_CNT    = (ADDR_WIDTH+1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH-1:0] WR_STEP   = ADDR_WIDTH'(PAR_WRITE);
    localparam logic [ADDR_WIDTH-1:0] RD_STEP   = ADDR_WIDTH'(PAR_READ);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  wr_fire;
    logic                  rd_fire;

    // Handshakes look only at the registered count: no read credit, no write-through.
    assign wr_ready     = (count_q <= DEPTH_CNT - WR_CNT);
    assign rd_valid     = (count_q >= RD_CNT);
    assign full         = !wr_ready;
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign count        = count_q;
    assign wr_fire      = wr_valid && wr_ready;
    assign rd_fire      = rd_valid && rd_ready;

    always_comb begin
        rd_data = '0;
        for (int j = 0; j < PAR_READ; j++) begin
            rd_data[j*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_ptr_q + ADDR_WIDTH'(j)];
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Flush drops pointers and count but leaves stale memory in place.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_fire) begin
                for (int i = 0; i < PAR_WRITE; i++) begin
                    mem_d[wr_ptr_q + ADDR_WIDTH'(i)] = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
                wr_ptr_d = wr_ptr_q + WR_STEP;
            end
            if (rd_fire) begin
                rd_ptr_d = rd_ptr_q + RD_STEP;
            end
            count_d = count_q + (wr_fire ? WR_CNT : '0) - (rd_fire ? RD_CNT : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

`ifdef WCFIFO_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (flush) begin
            err_d = 1'b0;
        end else if ((wr_valid && !wr_ready) || (rd_ready && !rd_valid)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_width_conv_fifo.sv
// Randomized scoreboard bench for width_conv_fifo; a word-queue reference model predicts count, flags and read data.
// Build with WCFIFO_ERR_EN defined to also check the sticky err output.
module tb_width_conv_fifo;

    localparam int DW    = 16;
    localparam int PW    = 2;
    localparam int PR    = 4;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic               clk;
    logic               rst;
    logic               flush;
    logic               wr_valid;
    logic               wr_ready;
    logic [PW*DW-1:0]   wr_data;
    logic               rd_valid;
    logic               rd_ready;
    logic [PR*DW-1:0]   rd_data;
    logic [AW:0]        count;
    logic               full;
    logic               empty;
    logic               almost_full;
    logic               almost_empty;
`ifdef WCFIFO_ERR_EN
    logic               err;
`endif

    width_conv_fifo dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_data(wr_data),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .rd_data(rd_data),
        .count(count),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty)
`ifdef WCFIFO_ERR_EN
        ,
        .err(err)
`endif
    );

    // Reference state: expected words in arrival order plus word occupancy.
    logic [DW-1:0] expQ[$];
    int            modelCount;
    logic          errModel;
    logic [DW-1:0] nextWord;
    logic          monitorOn;
    int            checks;
    int            errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [PW*DW-1:0] wordData();
        return {nextWord + 16'd1, nextWord};
    endfunction

    // Advance the reference model using the inputs the DUT samples at this edge.
    task automatic modelStep();
        logic canWrite, canRead;
        canWrite = (modelCount + PW <= DEPTH);
        canRead  = (modelCount >= PR);
        if (rst || flush) begin
            modelCount = 0;
            expQ.delete();
            errModel = 1'b0;
        end else begin
            if ((wr_valid && !canWrite) || (rd_ready && !canRead)) errModel = 1'b1;
            if (wr_valid && canWrite) begin
                for (int i = 0; i < PW; i++) expQ.push_back(wr_data[i*DW +: DW]);
                modelCount += PW;
                nextWord += 16'(PW);
            end
            if (rd_ready && canRead) modelCount -= PR;
        end
    endtask

    task automatic applyStimulus(input logic wv, input logic [PW*DW-1:0] wd, input logic rr,
                                 input logic fl, input logic rs);
        @(posedge clk);
        modelStep();
        #1;
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        flush    = fl;
        rst      = rs;
    endtask

    // Monitor: compares flags every cycle and pops expected words whenever a read beat is presented and taken.
    always @(negedge clk) begin
        if (monitorOn) begin
            logic [PR*DW-1:0] expData;
            checkOutput("count", 64'(count), 64'(modelCount));
            checkOutput("flags", 64'({wr_ready, full, rd_valid, empty, almost_full, almost_empty}),
                        64'({modelCount + PW <= DEPTH, modelCount + PW > DEPTH, modelCount >= PR,
                             modelCount == 0, modelCount >= 12, modelCount <= 4}));
`ifdef WCFIFO_ERR_EN
            checkOutput("err", 64'(err), 64'(errModel));
`endif
            if (rd_valid && expQ.size() >= PR) begin
                for (int j = 0; j < PR; j++) expData[j*DW +: DW] = expQ[j];
                checkOutput(rd_ready ? "rd_data_pop" : "rd_data_peek", 64'(rd_data), 64'(expData));
                if (rd_ready) begin
                    for (int j = 0; j < PR; j++) void'(expQ.pop_front());
                end
            end else if (rd_valid && rd_ready) begin
                checkOutput("rd_underflow_words", 64'(expQ.size()), 64'(PR));
            end
        end
    end

    initial begin
        checks     = 0;
        errors     = 0;
        modelCount = 0;
        errModel   = 1'b0;
        nextWord   = 16'h0100;
        monitorOn  = 1'b0;
        rst        = 1'b1;
        flush      = 1'b0;
        wr_valid   = 1'b0;
        rd_ready   = 1'b0;
        wr_data    = '0;

        applyStimulus(0, '0, 0, 0, 1);
        applyStimulus(0, '0, 0, 0, 1);
        applyStimulus(0, '0, 0, 0, 0);
        @(negedge clk);
        checkOutput("reset_count", 64'(count), 64'd0);
        checkOutput("reset_empty", 64'(empty), 64'd1);
        checkOutput("reset_wr_ready", 64'(wr_ready), 64'd1);
        checkOutput("reset_rd_valid", 64'(rd_valid), 64'd0);
        checkOutput("reset_almost_empty", 64'(almost_empty), 64'd1);
        checkOutput("reset_rd_data", 64'(rd_data), 64'd0);
        monitorOn = 1'b1;

        // Two narrow beats assemble into one wide beat.
        applyStimulus(1, 32'h0002_0001, 0, 0, 0);
        applyStimulus(1, 32'h0004_0003, 0, 0, 0);
        applyStimulus(0, '0, 0, 0, 0);
        @(negedge clk);
        checkOutput("conv_count", 64'(count), 64'd4);
        checkOutput("conv_rd_valid", 64'(rd_valid), 64'd1);
        checkOutput("conv_rd_data", 64'(rd_data), 64'h0004_0003_0002_0001);
        applyStimulus(0, '0, 1, 0, 0);
        applyStimulus(0, '0, 0, 0, 0);
        @(negedge clk);
        checkOutput("conv_drain_count", 64'(count), 64'd0);
        checkOutput("conv_drain_empty", 64'(empty), 64'd1);

        // Fill to capacity, then hold a ninth beat against full.
        for (int b = 0; b < 9; b++) applyStimulus(1, wordData(), 0, 0, 0);
        @(negedge clk);
        checkOutput("fill_count", 64'(count), 64'd16);
        checkOutput("fill_full", 64'(full), 64'd1);
        checkOutput("fill_wr_ready", 64'(wr_ready), 64'd0);
        checkOutput("fill_almost_full", 64'(almost_full), 64'd1);
        applyStimulus(1, wordData(), 0, 0, 0);
        @(negedge clk);
        checkOutput("held_count", 64'(count), 64'd16);
        applyStimulus(0, '0, 1, 0, 0);
        applyStimulus(0, '0, 0, 0, 0);
        @(negedge clk);
        checkOutput("after_read_count", 64'(count), 64'd12);
        checkOutput("after_read_wr_ready", 64'(wr_ready), 64'd1);

        // Reach count 6, then write and read in the same cycle.
        applyStimulus(0, '0, 1, 0, 0);
        applyStimulus(0, '0, 1, 0, 0);
        applyStimulus(1, wordData(), 0, 0, 0);
        applyStimulus(1, wordData(), 1, 0, 0);
        @(negedge clk);
        checkOutput("simul_pre_count", 64'(count), 64'd6);
        applyStimulus(0, '0, 0, 0, 0);
        @(negedge clk);
        checkOutput("simul_post_count", 64'(count), 64'd4);

        // Flush at count 10 discards the concurrent write.
        for (int b = 0; b < 3; b++) applyStimulus(1, wordData(), 0, 0, 0);
        applyStimulus(1, wordData(), 0, 1, 0);
        @(negedge clk);
        checkOutput("preflush_count", 64'(count), 64'd10);
        applyStimulus(0, '0, 0, 0, 0);
        @(negedge clk);
        checkOutput("flush_count", 64'(count), 64'd0);
        checkOutput("flush_empty", 64'(empty), 64'd1);

`ifdef WCFIFO_ERR_EN
        applyStimulus(0, '0, 1, 0, 0);
        applyStimulus(0, '0, 0, 0, 0);
        @(negedge clk);
        checkOutput("err_set", 64'(err), 64'd1);
        applyStimulus(0, '0, 0, 1, 0);
        applyStimulus(0, '0, 0, 0, 0);
        @(negedge clk);
        checkOutput("err_flush_clear", 64'(err), 64'd0);
`endif

        // Random traffic with incrementing words wraps the pointers many times.
        for (int c = 0; c < 800; c++) begin
            applyStimulus(($urandom_range(0, 99) < 60), wordData(), ($urandom_range(0, 99) < 50), 0, 0);
        end
        for (int c = 0; c < 8; c++) applyStimulus(0, '0, 1, 0, 0);
        applyStimulus(0, '0, 0, 0, 0);
        @(negedge clk);
        checkOutput("drain_words_left", 64'(expQ.size()), 64'(modelCount));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/width_conv_fifo.md
Name: width_conv_fifo

Overview:
Parametrised width-converting circular FIFO, the successor to the fixed-ratio counter/checker/buffer FIFO. It accepts PAR_WRITE words per write beat and returns PAR_READ words per read beat, with valid/ready handshakes on both sides. It tracks word-level occupancy, raises programmable almost-full/almost-empty flags and supports a synchronous flush. It sits between producer and consumer datapaths that run at different word parallelism.

Parameters:
DATA_WIDTH, 16, bits per word
PAR_WRITE, 2, words accepted per write beat
PAR_READ, 4, words delivered per read beat
DEPTH, 16, storage in words; power of two and a multiple of both PAR_WRITE and PAR_READ
ADDR_WIDTH, $clog2(DEPTH), word-pointer width
AF_THRESH, 12, almost_full asserts when count >= AF_THRESH
AE_THRESH, 4, almost_empty asserts when count <= AE_THRESH

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous clear of pointers and count
wr_valid  in  1  producer has a beat
wr_ready  out  1  FIFO can accept a beat
wr_data  in  PAR_WRITE*DATA_WIDTH  word 0 in LSBs
rd_valid  out  1  PAR_READ words are available
rd_ready  in  1  consumer takes the beat
rd_data  out  PAR_READ*DATA_WIDTH  oldest word in LSBs
count  out  ADDR_WIDTH+1  occupancy in words, 0..DEPTH
full  out  1  equals !wr_ready
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH

Behaviour:
- State: wr_ptr and rd_ptr (ADDR_WIDTH bits, word granularity, wrap modulo DEPTH), count register, DEPTH x DATA_WIDTH memory.
- Reset (rst=1 at an edge): pointers=0, count=0, memory cleared to 0. Outputs afterwards: wr_ready=1, full=0, rd_valid=0, empty=1, almost_empty=1, almost_full=0, rd_data=0.
- rst has priority over flush. flush clears pointers and count only, not memory, and overrides any write or read in the same cycle.
- wr_ready = (count <= DEPTH-PAR_WRITE). It is computed from the registered count only, with no same-cycle read credit.
- rd_valid = (count >= PAR_READ). It is computed from the registered count only, with no write-through.
- Write fire (wr_valid && wr_ready):
  - word i of wr_data goes to mem[(wr_ptr+i) mod DEPTH];
  - wr_ptr += PAR_WRITE, with wrap.
- Read fire (rd_valid && rd_ready):
  - rd_ptr += PAR_READ, with wrap.
- rd_data is show-ahead and combinational from memory: word j = mem[(rd_ptr+j) mod DEPTH]. It is stable while rd_valid=1 and no read fires.
- count_next = count + PAR_WRITE*wfire - PAR_READ*rfire. A simultaneous write and read are both honoured in the same edge.
- Data written in cycle N is visible on rd_data/rd_valid from cycle N+1.
- Flags are pure decodes of the registered count. There is no hidden latency.
- wr_valid while !wr_ready: no state change. The producer must hold its data.
- rd_ready while !rd_valid: no state change.
- Wrap-around: a write or read beat may straddle index DEPTH-1 to 0 when PAR does not divide the pointer offset. Word order must be preserved.

Optional Feature:
Macro WCFIFO_ERR_EN.
- Defined: adds output err (1 bit), reset to 0 by rst or flush.
  - err is sticky-set on any cycle with (wr_valid && !wr_ready) or (rd_ready && !rd_valid).
  - err cleared only by rst/flush.
- Undefined: no err port and no related logic. All other behaviour is identical.

Test Plan:
All scenarios use the default parameters.
- Reset: hold rst 2 cycles -> count=0, empty=1, wr_ready=1, rd_valid=0, almost_empty=1, rd_data=0.
- Width conversion: write 0x0002_0001 then 0x0004_0003, no reads -> count=4, rd_valid=1, rd_data=0x0004_0003_0002_0001. Pulse rd_ready -> count=0, empty=1.
- Fill/full: 8 consecutive writes -> count=16, full=1, wr_ready=0, almost_full=1. A 9th beat held on wr_valid leaves count=16. One read -> count=12, wr_ready=1.
- Simultaneous: at count=6, assert wr_valid and rd_ready in one cycle -> count=4, and rd_data advances by 4 words.
- Wrap-around: run 20 write beats and 10 read beats with incrementing word values and random gaps -> every read beat equals 4 consecutive values. Pointers wrap at least twice.
- Flush/reset mid-operation: at count=10, assert flush together with wr_valid -> count=0, empty=1, write discarded. With WCFIFO_ERR_EN, a prior read attempt at count=0 sets err=1, and flush clears it.
